// File: rtl/reg_bank_pkg.sv
// Shared types and default sizes for the register-bank write sequencer.
// Imported by the sequencer top, its request FIFO and the bench.
package reg_bank_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = 5;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } req_t;

endpackage

// File: rtl/reg_wr_fifo.sv
// Small synchronous FIFO holding pending register write requests.
// Overflowing pushes and underflowing pops are ignored.
module reg_wr_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rptr];

    // Storage array: written on accepted push only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/reg_bank_wr_seq.sv
// Write-port sequencer: queues requests and plays each one out as a
// SETUP / STROBE / HOLD sequence on the shared bus and one-hot strobes.
module reg_bank_wr_seq
    import reg_bank_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int NREGS    = DEF_NREGS,
    parameter int AW       = DEF_AW,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    input  logic [DW-1:0]    req_data,
    input  logic [NREGS-1:0] rd_lock,
    output logic [DW-1:0]    wr_data,
    output logic [NREGS-1:0] wr_strobe,
    output logic             busy,
    output logic [7:0]       zero_wr_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NA = 1 << AW;

    function automatic logic [NA-1:0] range_mask();
        logic [NA-1:0] m;
        m = '0;
        for (int i = 0; i < NA; i++) begin
            m[i] = (i < NREGS);
        end
        return m;
    endfunction

    localparam logic [NA-1:0] IN_RANGE = range_mask();

    state_t            state;
    state_t            state_nx;
    logic              live_q;
    logic [AW-1:0]     addr_q;
    logic [NREGS-1:0]  sel;
    logic              locked;
    logic              push;
    logic              pop;
    logic              load;
    logic              zero_hit;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [AW+DW-1:0]  head;
    logic [AW-1:0]     head_addr;
    logic [DW-1:0]     head_data;
    logic              is_zero;
    logic              drop;

    assign req_ready = live_q & (count < CW'(DEPTH));
    assign push      = req_valid & req_ready & ~full;
    assign {head_addr, head_data} = head;

    assign is_zero = (ZERO_REG != 0) && (head_addr == '0);
    assign drop    = is_zero | ~IN_RANGE[head_addr];

    assign sel    = NREGS'(1) << addr_q;
    assign locked = |(rd_lock & sel);
    assign busy   = ~empty | (state != IDLE);

    reg_wr_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({req_addr, req_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus pop/load/discard decisions from the FIFO head.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        load     = 1'b0;
        zero_hit = 1'b0;
        case (state)
            IDLE, HOLD: begin
                state_nx = IDLE;
                if (!empty) begin
                    pop = 1'b1;
                    if (drop) begin
                        zero_hit = is_zero;
                    end else begin
                        load     = 1'b1;
                        state_nx = SETUP;
                    end
                end
            end
            SETUP: begin
                if (!locked) begin
                    state_nx = STROBE;
                end
            end
            STROBE: begin
                state_nx = HOLD;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Bus data, flopped strobes, ready gating and discard counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live_q      <= 1'b0;
            addr_q      <= '0;
            wr_data     <= '0;
            wr_strobe   <= '0;
            zero_wr_cnt <= '0;
        end else begin
            live_q <= 1'b1;
            if (load) begin
                addr_q  <= head_addr;
                wr_data <= head_data;
            end
            if (state == SETUP && !locked) begin
                wr_strobe <= sel;
            end else begin
                wr_strobe <= '0;
            end
            if (zero_hit && zero_wr_cnt != 8'hFF) begin
                zero_wr_cnt <= zero_wr_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_wr_seq.sv
// Bench for reg_bank_wr_seq: directed timing steps plus a random phase,
// with an ordered queue of expected register writes.
module tb_reg_bank_wr_seq;
    import reg_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic [31:0] req_data;
    logic [31:0] rd_lock;
    logic [31:0] wr_data;
    logic [31:0] wr_strobe;
    logic        busy;
    logic [7:0]  zero_wr_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_zero = 0;
    bit   mon_en = 0;
    bit   rnd_en = 0;
    req_t exp_q[$];
    int   stamps[$];
    logic [31:0] prev_strobe = '0;

    reg_bank_wr_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rd_lock     (rd_lock),
        .wr_data     (wr_data),
        .wr_strobe   (wr_strobe),
        .busy        (busy),
        .zero_wr_cnt (zero_wr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every strobe must be the next expected write, one-hot, one cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_strobe != 0) begin
                chk("strobe_pulse", prev_strobe & wr_strobe, 0);
            end
            if (wr_strobe != 0) begin
                chk("onehot", $onehot0(wr_strobe), 1);
                chk("lock_env", rd_lock & wr_strobe, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", wr_strobe, 0);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    chk("strobe_addr", wr_strobe, 32'b1 << e.addr);
                    chk("strobe_data", wr_data, e.data);
                end
                stamps.push_back(cyc);
            end
            prev_strobe = wr_strobe;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (rnd_en && wr_strobe == 0) begin
            rd_lock = $urandom & $urandom & 32'hFFFF_FFFE;
        end
    endtask

    task automatic send(input logic [4:0] a, input logic [31:0] d);
        int   n;
        req_t r;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        n = 0;
        while (!req_ready && n < 200) begin
            step();
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        r.addr = a;
        r.data = d;
        if (a == 0) begin
            exp_zero = (exp_zero == 255) ? 255 : exp_zero + 1;
        end else begin
            exp_q.push_back(r);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int   b;
        logic [31:0] d;
        logic [4:0]  a;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        rd_lock   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_zcnt", zero_wr_cnt, 0);
        mon_en = 1;
        rst_n  = 1'b1;
        step();
        chk("rel_ready", req_ready, 1);
        chk("rel_busy", busy, 0);
        chk("rel_strobe", wr_strobe, 0);

        send(5'd5, 32'hDEAD_BEEF);
        chk("single_busy_t", busy, 1);
        step();
        chk("single_data_t1", wr_data, 32'hDEAD_BEEF);
        chk("single_strb_t1", wr_strobe, 0);
        step();
        chk("single_strb_t2", wr_strobe, 32'h20);
        step();
        chk("single_strb_t3", wr_strobe, 0);
        chk("single_data_t3", wr_data, 32'hDEAD_BEEF);
        step();
        chk("single_busy_t4", busy, 0);

        b = stamps.size();
        for (int i = 1; i <= 6; i++) begin
            send(5'(i), $urandom);
        end
        chk("burst_full", req_ready, 0);
        wait_idle(100);
        chk("burst_count", stamps.size(), b + 6);
        for (int i = 1; i < 6 && b + i < stamps.size(); i++) begin
            chk("burst_gap", stamps[b+i] - stamps[b+i-1], 3);
        end

        rd_lock = 32'h80;
        send(5'd7, 32'h0777_7777);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("stall_strobe", wr_strobe, 0);
            chk("stall_busy", busy, 1);
            step();
        end
        rd_lock = '0;
        step();
        chk("stall_release", wr_strobe, 32'h80);
        wait_idle(20);

        send(5'd0, 32'h1111_1111);
        send(5'd3, 32'h3333_3333);
        wait_idle(40);
        chk("zero_cnt1", zero_wr_cnt, exp_zero);
        chk("zero_drained", exp_q.size(), 0);

        rnd_en = 1;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            d = $urandom;
            send(a, d);
            repeat ($urandom_range(0, 3)) step();
        end
        rnd_en  = 0;
        rd_lock = '0;
        wait_idle(600);
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_zcnt", zero_wr_cnt, exp_zero);

        for (int i = 0; i < 300; i++) begin
            send(5'd0, $urandom);
        end
        wait_idle(20);
        chk("zero_sat", zero_wr_cnt, 255);
        chk("zero_sat_model", zero_wr_cnt, exp_zero);

        rd_lock = 32'h400;
        send(5'd10, $urandom);
        send(5'd11, $urandom);
        send(5'd12, $urandom);
        send(5'd13, $urandom);
        rd_lock = '0;
        step();
        chk("midop_strobe", wr_strobe, 32'h400);
        rst_n = 1'b0;
        step();
        exp_q.delete();
        exp_zero = 0;
        chk("midop_drop", wr_strobe, 0);
        chk("midop_busy", busy, 0);
        chk("midop_ready", req_ready, 0);
        chk("midop_zcnt", zero_wr_cnt, 0);
        b = stamps.size();
        rst_n = 1'b1;
        step();
        chk("midop_rel_ready", req_ready, 1);
        repeat (20) step();
        chk("midop_no_strobe", stamps.size(), b);
        chk("midop_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_wr_seq.md
Name: reg_bank_wr_seq

Overview:
- Write-port sequencer sitting directly upstream of the bank of reg_32 registers.
- Accepts write requests (address + data) over a valid/ready handshake and buffers them in a small FIFO.
- Converts each request into a glitch-free SETUP / STROBE / HOLD sequence on the shared data bus and the target register's one-hot writereg line.
- Honours the per-register read lock (readreg), which gates a register's capture clock.

Parameters:
- DW, 32, data width; matches reg_32 width.
- NREGS, 32, number of registers in the bank.
- AW, 5, address width; must satisfy 2**AW >= NREGS.
- DEPTH, 4, request FIFO depth; power of two, at least 2.
- ZERO_REG, 1, when 1, register 0 is read-only zero and writes to it are discarded.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- req_valid  in  1  write request valid.
- req_ready  out  1  FIFO can accept a request.
- req_addr  in  AW  target register index.
- req_data  in  DW  write data.
- rd_lock  in  NREGS  per-register readreg level; a 1 blocks writes to that register.
- wr_data  out  DW  shared data bus to every reg_32 "in".
- wr_strobe  out  NREGS  one-hot writereg lines, each driven from a flop.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- zero_wr_cnt  out  8  saturating count of discarded register-0 writes.

Behaviour:
- Reset (rst_n=0 at a rising edge): FIFO emptied; FSM to IDLE; wr_data=0; wr_strobe=0; zero_wr_cnt=0; busy=0; req_ready=0 during reset, 1 from the first cycle after release.
- Reset mid-sequence: wr_strobe drops at that edge and the pending write is lost. Required: no partial strobe longer than one cycle.
- Handshake:
  - Transfer occurs when req_valid & req_ready at an edge.
  - req_ready = (count < DEPTH), registered-count based. There is no combinational path from req_valid to req_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Address >= NREGS: dropped at pop; no strobe; not counted.
- FSM, one state register:
  - IDLE: if FIFO non-empty, pop. If the popped address is 0 and ZERO_REG=1, or the address is out of range, discard it, stay IDLE, and bump zero_wr_cnt (register-0 case only, saturates at 255). Otherwise latch addr/data, drive wr_data, go SETUP.
  - SETUP: wr_data stable, wr_strobe=0. Advance to STROBE only when rd_lock[addr]=0 at this edge; otherwise stay in SETUP indefinitely (lock stall).
  - STROBE: wr_strobe[addr]=1 for exactly one cycle. The reg_32 captures on the strobe rising edge. Go HOLD.
  - HOLD: wr_strobe=0, wr_data unchanged. If FIFO non-empty, pop directly (same discard rules as IDLE) and go SETUP with the new data; else go IDLE.
- Latency: request accepted at edge t → SETUP from t+1 → strobe high t+2..t+3 → HOLD t+3..t+4. Minimum 3 cycles per write; sustained throughput is 1 write per 3 cycles.
- wr_data changes only on entry to SETUP. It never changes while any wr_strobe bit is 1 or during HOLD.
- Write ordering is strictly FIFO. Back-to-back writes to the same register are both performed; the last one wins.
- Environment rule: rd_lock[addr] must not rise during STROBE for the register being written. Benches flag a violation as an assertion failure.
- At most one wr_strobe bit is ever set (assert $onehot0).

Decomposition:
- Package reg_bank_pkg:
  - Default DW/NREGS/AW constants.
  - State enum {IDLE, SETUP, STROBE, HOLD}.
  - Request struct {addr, data}.
- One sub-module, reg_wr_fifo:
  - Parameterised DEPTH×(AW+DW) synchronous FIFO.
  - Ports: push, pop, full, empty, count.
  - Synchronous active-low reset.
- FSM, one-hot decode and zero counter live in the top module.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0 for 3 cycles, then release with req_valid=0.
  - Required: wr_strobe=0, wr_data=0, busy=0, req_ready=1 one cycle after release.
- Single write:
  - Stimulus: addr=5, data=0xDEADBEEF accepted at t.
  - Required: wr_data=0xDEADBEEF from t+1; wr_strobe=32'h20 only in t+2..t+3; busy low from t+4.
- Burst/backpressure:
  - Stimulus: 6 consecutive requests (addr 1..6) with req_valid held high.
  - Required: req_ready drops after 4 outstanding; strobes fire in order 1..6, spaced exactly 3 cycles apart.
- Lock stall:
  - Stimulus: rd_lock[7]=1 held for 10 cycles; write to addr 7.
  - Required: FSM remains in SETUP with wr_strobe=0 throughout; strobe occurs on the cycle after rd_lock[7] clears.
- Register 0 discard:
  - Stimulus: writes to addr 0, then addr 3.
  - Required: no strobe for addr 0; zero_wr_cnt=1; addr 3 strobes.
  - Stimulus: 300 addr-0 writes.
  - Required: zero_wr_cnt saturates at 255.
- Reset mid-op:
  - Stimulus: assert rst_n=0 during STROBE with 3 requests queued.
  - Required: strobe low next cycle, FIFO empty, and no further strobes after release.
